// File: rtl/data_mem_ctrl.sv
// Single-port word-organised data memory with RV32I byte/half/word access,
// alignment/range checking and a configurable number of wait states.
package pkg_config;
    localparam int DATA_WIDTH = 32;
endpackage

module data_mem_ctrl
    import pkg_config::*;
#(
    parameter int MEM_SIZE    = 1024,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  ready_o,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o
);
    localparam int IDX_W = $clog2(MEM_SIZE);
    localparam logic [2:0] WS_LAST = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [2:0]              f3_q, f3_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem [MEM_SIZE];

    logic                    accept, commit, mem_we;
    logic                    cur_we;
    logic [2:0]              cur_f3;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [DATA_WIDTH-1:0]   cur_wdata;
    logic [IDX_W-1:0]        idx;
    logic [1:0]              off;
    logic                    illegal, misalign, oob, acc_err;
    logic [DATA_WIDTH-1:0]   rd_word, lane_b, lane_h, load_val, wword;
    logic [3:0]              be;

    assign ready_o     = rst_ni && (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign accept      = req_i && ready_o;

    // With zero wait states the commit edge is the accept edge, so the live
    // inputs are decoded directly; otherwise the captured request is used.
    assign cur_we    = (state_q == ST_IDLE) ? we_i     : we_q;
    assign cur_f3    = (state_q == ST_IDLE) ? funct3_i : f3_q;
    assign cur_addr  = (state_q == ST_IDLE) ? addr_i   : addr_q;
    assign cur_wdata = (state_q == ST_IDLE) ? wdata_i  : wdata_q;

    always_comb begin
        off      = cur_addr[1:0];
        idx      = cur_addr[IDX_W+1:2];
        oob      = (ADDR_WIDTH > IDX_W + 2) ? |(cur_addr >> (IDX_W + 2)) : 1'b0;
        misalign = ((cur_f3[1:0] == 2'b01) && off[0]) ||
                   ((cur_f3[1:0] == 2'b10) && (off != 2'b00));
        if (cur_we) illegal = (cur_f3 != 3'b000) && (cur_f3 != 3'b001) && (cur_f3 != 3'b010);
        else        illegal = (cur_f3 == 3'b011) || (cur_f3 == 3'b110) || (cur_f3 == 3'b111);
        acc_err  = illegal || misalign || oob;

        rd_word  = mem[idx];
        lane_b   = rd_word >> {off, 3'b000};
        lane_h   = rd_word >> {off[1], 4'b0000};
        case (cur_f3)
            3'b000:  load_val = {{24{lane_b[7]}}, lane_b[7:0]};
            3'b001:  load_val = {{16{lane_h[15]}}, lane_h[15:0]};
            3'b100:  load_val = {24'd0, lane_b[7:0]};
            3'b101:  load_val = {16'd0, lane_h[15:0]};
            default: load_val = rd_word;
        endcase

        case (cur_f3[1:0])
            2'b00: begin
                be    = 4'b0001 << off;
                wword = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << off;
                wword = {2{cur_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wword = cur_wdata;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = we_i;
                    f3_d    = funct3_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    cnt_d   = 3'd0;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == WS_LAST) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
        if (commit) begin
            err_d   = acc_err;
            rdata_d = (acc_err || cur_we) ? '0 : load_val;
        end
    end

    assign mem_we = commit && cur_we && !acc_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance without wait states and one
// with three, covering sub-word access, error cases, timing and reset abort.
module tb_data_mem_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // zero-wait-state instance
    logic        rst0_n, req0, we0, ready0, rsp0, err0;
    logic [2:0]  f30;
    logic [31:0] addr0, wdata0, rdata0;
    // three-wait-state instance
    logic        rst3_n, req3, we3, ready3, rsp3, err3;
    logic [2:0]  f33;
    logic [31:0] addr3, wdata3, rdata3;

    data_mem_ctrl #(.MEM_SIZE(1024), .WAIT_STATES(0), .ADDR_WIDTH(32)) dut0 (
        .clk_i(clk), .rst_ni(rst0_n), .req_i(req0), .we_i(we0), .funct3_i(f30),
        .addr_i(addr0), .wdata_i(wdata0), .ready_o(ready0), .rsp_valid_o(rsp0),
        .rdata_o(rdata0), .err_o(err0)
    );

    data_mem_ctrl #(.MEM_SIZE(16), .WAIT_STATES(3), .ADDR_WIDTH(32)) dut3 (
        .clk_i(clk), .rst_ni(rst3_n), .req_i(req3), .we_i(we3), .funct3_i(f33),
        .addr_i(addr3), .wdata_i(wdata3), .ready_o(ready3), .rsp_valid_o(rsp3),
        .rdata_o(rdata3), .err_o(err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns response data, error and data one cycle later.
    task automatic acc0(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output logic [31:0] rd_hold);
        int guard = 0;
        while (!ready0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("acc0_ready", {31'd0, ready0}, 32'd1);
        req0 = 1'b1; we0 = we; f30 = f3; addr0 = addr; wdata0 = wd;
        @(posedge clk); #1;
        req0 = 1'b0; we0 = 1'b0; f30 = 3'b111; addr0 = 32'hFFFF_FFFF; wdata0 = 32'h0;
        check("acc0_rsp", {31'd0, rsp0}, 32'd1);
        rd = rdata0;
        er = err0;
        @(posedge clk); #1;
        check("acc0_strobe_end", {31'd0, rsp0}, 32'd0);
        rd_hold = rdata0;
        @(negedge clk);
    endtask

    // Called at a negedge with dut3 idle; checks latency and returns the response.
    task automatic acc3(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int cyc;
        check("acc3_ready", {31'd0, ready3}, 32'd1);
        req3 = 1'b1; we3 = we; f33 = f3; addr3 = addr; wdata3 = wd;
        @(posedge clk); #1;
        req3 = 1'b0; addr3 = 32'h0000_0008; wdata3 = 32'hFFFF_FFFF;
        cyc = 1;
        while (!rsp3 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("acc3_latency", cyc, 32'd4);
        rd = rdata3;
        er = err3;
        @(negedge clk);
    endtask

    logic [31:0] rd, rh;
    logic        er;
    int          pulses;

    initial begin
        rst0_n = 1'b0; rst3_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; f30 = 3'b010; addr0 = '0; wdata0 = '0;
        req3 = 1'b0; we3 = 1'b0; f33 = 3'b010; addr3 = '0; wdata3 = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready0}, 32'd0);
        check("rst_rsp", {31'd0, rsp0}, 32'd0);
        check("rst_rdata", rdata0, 32'd0);
        check("rst_err", {31'd0, err0}, 32'd0);
        check("rst_ready3", {31'd0, ready3}, 32'd0);
        rst0_n = 1'b1; rst3_n = 1'b1;
        #1;
        check("ready_after_rst", {31'd0, ready0}, 32'd1);
        @(negedge clk);

        // word store/load, then sub-word accesses
        acc0(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, er, rh);
        check("sw_err", {31'd0, er}, 32'd0);
        acc0(1'b0, 3'b010, 32'h10, 32'h0, rd, er, rh);
        check("lw_data", rd, 32'hDEAD_BEEF);
        check("lw_err", {31'd0, er}, 32'd0);
        check("lw_hold", rh, 32'hDEAD_BEEF);
        acc0(1'b1, 3'b000, 32'h11, 32'h0000_00A5, rd, er, rh);
        acc0(1'b0, 3'b010, 32'h10, 32'h0, rd, er, rh);
        check("sb_merge", rd, 32'hDEAD_A5EF);
        acc0(1'b0, 3'b000, 32'h11, 32'h0, rd, er, rh);
        check("lb", rd, 32'hFFFF_FFA5);
        acc0(1'b0, 3'b100, 32'h11, 32'h0, rd, er, rh);
        check("lbu", rd, 32'h0000_00A5);
        acc0(1'b0, 3'b101, 32'h12, 32'h0, rd, er, rh);
        check("lhu", rd, 32'h0000_DEAD);
        acc0(1'b0, 3'b001, 32'h12, 32'h0, rd, er, rh);
        check("lh", rd, 32'hFFFF_DEAD);
        acc0(1'b0, 3'b000, 32'h10, 32'h0, rd, er, rh);
        check("lb_lane0", rd, 32'hFFFF_FFEF);
        acc0(1'b1, 3'b001, 32'h12, 32'hABCD_1234, rd, er, rh);
        acc0(1'b0, 3'b010, 32'h10, 32'h0, rd, er, rh);
        check("sh_merge", rd, 32'h1234_A5EF);
        acc0(1'b0, 3'b100, 32'h13, 32'h0, rd, er, rh);
        check("lbu_lane3", rd, 32'h0000_0012);

        // error cases
        acc0(1'b0, 3'b010, 32'h13, 32'h0, rd, er, rh);
        check("lw_misalign_err", {31'd0, er}, 32'd1);
        check("lw_misalign_rdata", rd, 32'd0);
        check("err_hold", rh, 32'd0);
        acc0(1'b1, 3'b010, 32'h20, 32'h1122_3344, rd, er, rh);
        acc0(1'b1, 3'b001, 32'h21, 32'h0000_FFFF, rd, er, rh);
        check("sh_misalign_err", {31'd0, er}, 32'd1);
        acc0(1'b1, 3'b011, 32'h20, 32'h0, rd, er, rh);
        check("st_illegal_err", {31'd0, er}, 32'd1);
        acc0(1'b0, 3'b010, 32'h20, 32'h0, rd, er, rh);
        check("word20_kept", rd, 32'h1122_3344);
        check("word20_err", {31'd0, er}, 32'd0);
        acc0(1'b0, 3'b010, 32'h1000, 32'h0, rd, er, rh);
        check("oob_err", {31'd0, er}, 32'd1);
        check("oob_rdata", rd, 32'd0);
        acc0(1'b0, 3'b011, 32'h0, 32'h0, rd, er, rh);
        check("ld_illegal_err", {31'd0, er}, 32'd1);

        // wait-state timing with req held high through the busy window
        check("ws_ready0", {31'd0, ready3}, 32'd1);
        req3 = 1'b1; we3 = 1'b1; f33 = 3'b010; addr3 = 32'h4; wdata3 = 32'h55AA_55AA;
        @(posedge clk); #1;
        addr3 = 32'h8; wdata3 = 32'hFFFF_FFFF;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ws_ready_c%0d", k), {31'd0, ready3}, 32'd0);
            check($sformatf("ws_rsp_c%0d", k), {31'd0, rsp3}, (k == 4) ? 32'd1 : 32'd0);
            if (k == 4) req3 = 1'b0;
            else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        check("ws_idle_ready", {31'd0, ready3}, 32'd1);
        check("ws_idle_rsp", {31'd0, rsp3}, 32'd0);
        @(negedge clk);
        acc3(1'b0, 3'b010, 32'h4, 32'h0, rd, er);
        check("ws_lw_data", rd, 32'h55AA_55AA);
        check("ws_lw_err", {31'd0, er}, 32'd0);

        // reset during the wait window aborts the store
        req3 = 1'b1; we3 = 1'b1; f33 = 3'b010; addr3 = 32'h4; wdata3 = 32'h1234_5678;
        @(posedge clk); #1;
        req3 = 1'b0; we3 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst3_n = 1'b0;
        #1;
        check("abort_ready_in_rst", {31'd0, ready3}, 32'd0);
        check("abort_rsp_in_rst", {31'd0, rsp3}, 32'd0);
        @(negedge clk);
        rst3_n = 1'b1;
        #1;
        check("abort_ready_after", {31'd0, ready3}, 32'd1);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (rsp3) pulses++;
        end
        check("abort_no_rsp", pulses, 32'd0);
        @(negedge clk);
        acc3(1'b0, 3'b010, 32'h4, 32'h0, rd, er);
        check("abort_word_kept", rd, 32'h55AA_55AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, memory depth in 32-bit words (power of two, at least 4).
REQ-002 SHALL have parameter WAIT_STATES, default 0, extra access cycles (0..7).
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, byte-address width; DATA_WIDTH SHALL come from pkg_config and equal 32.
REQ-004 SHALL use one clock and an asynchronous, active-low reset:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
REQ-005 SHALL have the following remaining ports:
- req_i  in  1  request valid.
- we_i  in  1  1=store, 0=load.
- funct3_i  in  3  RV32I size code.
- addr_i  in  ADDR_WIDTH  byte address.
- wdata_i  in  DATA_WIDTH  store data, right-aligned.
- ready_o  out  1  request may be accepted.
- rsp_valid_o  out  1  response strobe.
- rdata_o  out  DATA_WIDTH  load result, extended.
- err_o  out  1  access fault.

Function
REQ-006 SHALL accept a request on a rising edge where req_i=1 and ready_o=1, capturing we_i, funct3_i, addr_i and wdata_i; later input changes SHALL be ignored.
REQ-007 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE:
- IDLE->WAIT on accept when WAIT_STATES>0.
- IDLE->RESP on accept when WAIT_STATES=0.
- WAIT->RESP after WAIT_STATES cycles, counted by an internal counter.
- RESP->IDLE unconditionally.
REQ-008 ready_o SHALL be 1 only in IDLE; req_i outside IDLE SHALL be ignored, with no queuing.
REQ-009 rsp_valid_o SHALL be 1 for exactly one cycle (RESP), WAIT_STATES+1 cycles after the accept edge.
REQ-010 Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; the lane is selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-011 Stores: funct3 000 SB, 001 SH, 010 SW; byte enables are derived from addr[1:0]; unselected bytes of the word SHALL be unchanged.
REQ-012 The word index SHALL be addr[$clog2(MEM_SIZE)+1:2].
REQ-013 A store SHALL commit on the edge entering RESP; load data SHALL be sampled on that same edge.
REQ-014 err_o=1 with rsp_valid_o SHALL be raised for any of:
- halfword with addr[0]=1;
- word with addr[1:0]!=0;
- addr >= 4*MEM_SIZE;
- illegal funct3, i.e. loads 011/110/111 and stores other than 000/001/010.
REQ-015 On error: no memory write, rdata_o=0.
REQ-016 rdata_o and err_o SHALL be registered and SHALL hold their value until the next RESP.
REQ-017 A load following a store to the same word SHALL return the updated data.
REQ-018 Memory array contents SHALL be neither reset nor initialised by the block.

Reset
REQ-019 While rst_ni=0:
- state=IDLE, wait counter=0;
- ready_o=0, rsp_valid_o=0, rdata_o=0, err_o=0.
REQ-020 After rst_ni rises, ready_o SHALL be 1 from the first cycle.
REQ-021 Reset asserted mid-operation (WAIT or before the commit edge) SHALL abort the access with no write and no response; memory contents SHALL be retained.

Verification
REQ-022 WAIT_STATES=0: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid_o one cycle after each accept, rdata_o=0xDEADBEEF, err_o=0.
REQ-023 Word 0x10=0xDEADBEEF, then:
- SB addr 0x11 data 0x000000A5, then LW 0x10 -> 0xDEADA5EF;
- LB 0x11 -> 0xFFFFFFA5;
- LBU 0x11 -> 0x000000A5;
- LHU 0x12 -> 0x0000DEAD.
REQ-024 Errors:
- LW 0x13 -> err_o=1, rdata_o=0;
- SH 0x21 -> err_o=1, word 0x20 unchanged;
- LW 4*MEM_SIZE -> err_o=1;
- funct3=011 load -> err_o=1.
REQ-025 WAIT_STATES=3: accept at cycle 0 -> ready_o=0 for cycles 1..4, rsp_valid_o=1 at cycle 4 only; req_i held high in cycles 1..4 is not accepted.
REQ-026 WAIT_STATES=3: SW issued, rst_ni pulsed low in cycle 2 -> no rsp_valid_o, target word keeps its old value, ready_o=1 after release.
